// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and a parity helper.
// Used by the transmitter and intended for reuse by the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } uart_state_e;

    localparam int unsigned ParityNone = 0;
    localparam int unsigned ParityEven = 1;
    localparam int unsigned ParityOdd  = 2;

    localparam int unsigned MaxDataW = 9;

    // Even parity is the plain XOR of the data bits; odd is its inverse.
    function automatic logic calc_parity(logic [MaxDataW-1:0] word, int unsigned mode);
        return (mode == ParityOdd) ? ~(^word) : ^word;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word-input handshake of the UART transmitter: valid/ready with a data word.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled, restarting at each tick.
// tick_early fires one cycle before tick so the final stop bit can hand over to IDLE.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic tick_early
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntEarly = CntW'(CLKS_PER_BIT - 2);

    logic [CntW-1:0] cnt_q;

    assign tick       = en && (cnt_q == CntLast);
    assign tick_early = en && (cnt_q == CntEarly);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// STOP_BITS stop bits. tx is registered; tx_done marks the last cycle of the final stop bit.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_cfg_if.slave host,
    output logic         tx,
    output logic         busy,
    output logic         tx_done
);
    if (DATA_W < 5 || DATA_W > MaxDataW) begin : g_bad_data_w
        $error("uart_tx_cfg: DATA_W must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY > ParityOdd) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned IdxW = $clog2(DATA_W);
    localparam logic [IdxW-1:0] IdxLastData = IdxW'(DATA_W - 1);
    localparam logic [IdxW-1:0] IdxLastStop = IdxW'(STOP_BITS - 1);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              tick, tick_early;
    logic [MaxDataW-1:0] word_ext;

    assign word_ext      = MaxDataW'(host.in_data);
    assign host.in_ready = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign tx            = tx_q;
    assign tx_done       = done_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .en        (busy),
        .tick      (tick),
        .tick_early(tick_early)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (host.in_valid) begin
                    state_d = StStart;
                    shift_d = host.in_data;
                    par_d   = calc_parity(word_ext, PARITY);
                    idx_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (idx_q == IdxLastData) begin
                        idx_d = '0;
                        if (PARITY != ParityNone) begin
                            state_d = StPar;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = {1'b0, shift_q[DATA_W-1:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            StPar: begin
                if (tick) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                // Final stop bit leaves one cycle early: its last cycle is the IDLE/done
                // cycle, so a word accepted there starts with no idle gap.
                if (idx_q == IdxLastStop) begin
                    if (tick_early) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end
                end else if (tick) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five configurations checked cycle by cycle against a frame model
// built from the framing rules, with directed and random words.
module tb_uart_tx_cfg;
    localparam int NDut = 5;

    // 0: defaults, CPB 4 | 1: even parity | 2: odd parity | 3: two stop bits | 4: 5-bit, CPB 2
    function automatic int cfg_dw(int k);
        return (k == 4) ? 5 : 8;
    endfunction
    function automatic int cfg_cpb(int k);
        return (k == 4) ? 2 : 4;
    endfunction
    function automatic int cfg_par(int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction
    function automatic int cfg_sb(int k);
        return (k == 3) ? 2 : 1;
    endfunction

    logic       clk;
    logic       rst;
    logic       vld [NDut];
    logic [8:0] dat [NDut];
    logic       rdy [NDut];
    logic       txs [NDut];
    logic       bsy [NDut];
    logic       dn  [NDut];

    int n_checks = 0;
    int n_err    = 0;

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        localparam int unsigned Dw = cfg_dw(g);
        uart_tx_cfg_if #(.DATA_W(Dw)) ifc ();
        assign ifc.in_valid = vld[g];
        assign ifc.in_data  = dat[g][Dw-1:0];
        assign rdy[g]       = ifc.in_ready;
        uart_tx_cfg #(
            .DATA_W      (Dw),
            .CLKS_PER_BIT(cfg_cpb(g)),
            .PARITY      (cfg_par(g)),
            .STOP_BITS   (cfg_sb(g))
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .host   (ifc),
            .tx     (txs[g]),
            .busy   (bsy[g]),
            .tx_done(dn[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line level for every bit of a frame, in transmission order.
    task automatic build_frame(input int k, input logic [8:0] w, output logic bits [$]);
        int ones;
        bits = {};
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < cfg_dw(k); i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (cfg_par(k) == 1) bits.push_back(logic'(ones % 2 == 1));
        if (cfg_par(k) == 2) bits.push_back(logic'(ones % 2 == 0));
        for (int i = 0; i < cfg_sb(k); i++) bits.push_back(1'b1);
    endtask

    // Returns #1 after the accept edge; waited counts idle cycles before the accept.
    task automatic wait_accept(input int k, output int waited);
        logic got;
        got = 1'b0;
        waited = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (rdy[k] && vld[k]) begin
                got = 1'b1;
                break;
            end
            waited++;
        end
        chk($sformatf("d%0d accept seen", k), 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after the accept edge; leaves #1 into the tx_done cycle.
    task automatic check_frame(input int k, input logic [8:0] w, input string tag);
        logic bits [$];
        int   n;
        build_frame(k, w, bits);
        n = bits.size() * cfg_cpb(k);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("d%0d %s tx j%0d", k, tag, j), 32'(txs[k]), 32'(bits[j / cfg_cpb(k)]));
            chk($sformatf("d%0d %s done j%0d", k, tag, j), 32'(dn[k]), 32'(j == n - 1));
            chk($sformatf("d%0d %s busy j%0d", k, tag, j), 32'(bsy[k]), 32'(j != n - 1));
            if (j != n - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send(input int k, input logic [8:0] w, input string tag);
        int waited;
        dat[k] = w;
        vld[k] = 1'b1;
        wait_accept(k, waited);
        vld[k] = 1'b0;
        check_frame(k, w, tag);
    endtask

    initial begin
        int waited;
        logic [8:0] w;
        rst = 1'b1;
        for (int k = 0; k < NDut; k++) begin
            vld[k] = 1'b0;
            dat[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDut; k++) begin
            chk($sformatf("d%0d reset tx", k), 32'(txs[k]), 32'd1);
            chk($sformatf("d%0d reset ready", k), 32'(rdy[k]), 32'd1);
            chk($sformatf("d%0d reset busy", k), 32'(bsy[k]), 32'd0);
            chk($sformatf("d%0d reset done", k), 32'(dn[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        send(0, 9'h0A5, "a5");
        send(1, 9'h007, "even07");
        send(2, 9'h000, "odd00");
        send(4, 9'h01F, "w5_1f");

        // Held valid: second word must start right after the first frame's last stop cycle.
        dat[3] = 9'h055;
        vld[3] = 1'b1;
        wait_accept(3, waited);
        dat[3] = 9'h0AA;
        check_frame(3, 9'h055, "b2b55");
        wait_accept(3, waited);
        chk("d3 back-to-back gap", 32'(waited), 32'd0);
        vld[3] = 1'b0;
        check_frame(3, 9'h0AA, "b2bAA");

        // Input changes mid-frame must not disturb the word in flight.
        dat[0] = 9'h03C;
        vld[0] = 1'b1;
        wait_accept(0, waited);
        dat[0] = 9'h0FF;
        check_frame(0, 9'h03C, "3c");
        wait_accept(0, waited);
        chk("d0 held ff gap", 32'(waited), 32'd0);
        vld[0] = 1'b0;
        check_frame(0, 9'h0FF, "ff");

        // Reset during data bit 3 aborts the frame.
        dat[0] = 9'h05A;
        vld[0] = 1'b1;
        wait_accept(0, waited);
        vld[0] = 1'b0;
        repeat (4 * 4 + 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("d0 rst tx", 32'(txs[0]), 32'd1);
        chk("d0 rst busy", 32'(bsy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("d0 post-rst ready", 32'(rdy[0]), 32'd1);
        for (int c = 0; c < 50; c++) begin
            chk("d0 post-rst no done", 32'(dn[0]), 32'd0);
            chk("d0 post-rst idle tx", 32'(txs[0]), 32'd1);
            @(posedge clk);
            #1;
        end
        send(0, 9'h0C3, "after_rst");

        // Reset wins over a simultaneous accept.
        @(negedge clk);
        dat[0] = 9'h011;
        vld[0] = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        vld[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("d0 rst priority busy", 32'(bsy[0]), 32'd0);
        chk("d0 rst priority tx", 32'(txs[0]), 32'd1);

        for (int k = 0; k < NDut; k++) begin
            for (int r = 0; r < 6; r++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                w = 9'($urandom) & ((9'd1 << cfg_dw(k)) - 9'd1);
                send(k, w, $sformatf("rnd%0d", r));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range >= 2.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 Port clk, input, 1: clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset; synchronous, active-high.
REQ-007 Port in_valid, input, 1: in_data holds a word to send.
REQ-008 Port in_ready, output, 1: block can accept a word this cycle.
REQ-009 Port in_data, input, DATA_W: word to transmit, sent LSB first.
REQ-010 Port tx, output, 1: serial line, idle high; driven from a register.
REQ-011 Port busy, output, 1: a frame is in progress.
REQ-012 Port tx_done, output, 1: one-cycle pulse marking frame completion.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL equal NOT in_ready.
REQ-015 A word SHALL be accepted on an edge where in_valid AND in_ready are both 1; it is captured into the shift register and the state moves to START.
REQ-016 Frame SHALL be: 1 start bit (0), DATA_W data bits LSB first, an optional parity bit, then STOP_BITS stop bits (1).
REQ-017 Each bit SHALL hold tx for exactly CLKS_PER_BIT cycles, timed by a bit counter that restarts at every bit boundary.
REQ-018 tx SHALL go low in the first cycle after the accept edge.
REQ-019 Transitions: START->DATA after one bit; DATA->PAR (PARITY!=0) or ->STOP after DATA_W bits; PAR->STOP after one bit; STOP->IDLE after STOP_BITS bits.
REQ-020 Parity SHALL be computed from the captured word: even = XOR of all data bits; odd = inverse of that XOR.
REQ-021 tx_done SHALL be 1 for exactly one cycle: the first IDLE cycle after the last stop bit, i.e. F*CLKS_PER_BIT cycles after the accept edge, where F = 1 + DATA_W + (PARITY!=0) + STOP_BITS.
REQ-022 An accept in the same cycle as tx_done SHALL be legal; the next start bit then follows the last stop bit with zero idle gap.
REQ-023 Changes to in_data or in_valid while busy SHALL NOT affect the frame in flight.
REQ-024 A held in_valid SHALL be accepted at the next IDLE cycle.
REQ-025 Illegal parameter values SHALL trigger an elaboration-time error.

Reset
REQ-026 During rst: tx = 1, in_ready = 1, busy = 0, tx_done = 0, state = IDLE, counters = 0, shift register = 0.
REQ-027 rst mid-frame SHALL abort the frame: tx = 1 from the next cycle, no tx_done pulse, and in_ready = 1 in the first cycle after rst deasserts.
REQ-028 rst SHALL take priority over a simultaneous accept.

Structure
REQ-029 The state encoding and the parity-mode constants (NONE/EVEN/ODD) SHALL live in the shared package uart_pkg, for reuse by the matching receiver.
REQ-030 Bit timing SHALL be a sub-module, uart_baud_gen: a CLKS_PER_BIT counter with an enable and a one-cycle tick output.
REQ-031 Counter widths SHALL be $clog2-derived from the parameters, with no hard-coded widths.

Verification
REQ-032 Defaults except CLKS_PER_BIT=4: send 0xA5 -> tx shows 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; tx_done 40 cycles after accept.
REQ-033 PARITY=1: send 0x07 -> parity bit 1; PARITY=2: send 0x00 -> parity bit 1; frame length 11 bits.
REQ-034 STOP_BITS=2, in_valid held high with 0x55 then 0xAA -> two frames, each ending in 2 high stop bits, with no idle gap between them.
REQ-035 Assert rst during data bit 3 -> tx = 1 next cycle, no tx_done pulse, next word is sent correctly.
REQ-036 Accept 0x3C, then drive in_data=0xFF with in_valid high mid-frame -> 0x3C transmitted intact; 0xFF accepted at the next IDLE cycle.
REQ-037 DATA_W=5, CLKS_PER_BIT=2: send 0x1F -> start bit, five 1s, stop bit; tx_done 14 cycles after accept.
